// File: rtl/saa1099_wr_queue_if.sv
// Bundle between the CPU port decoder, the write queue and the SAA1099 pins.
// master drives the CPU-side requests; slave is the queue itself.
interface saa1099_wr_queue_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic                  cpu_we;
    logic                  cpu_a0;
    logic [7:0]            cpu_din;
    logic                  ovf_clr;
    logic                  full;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic                  saa_cs_n;
    logic                  saa_a0;
    logic                  saa_wr_n;
    logic [7:0]            saa_din;

    modport master (
        output cpu_we, cpu_a0, cpu_din, ovf_clr,
        input  full, level, overflow, saa_cs_n, saa_a0, saa_wr_n, saa_din
    );

    modport slave (
        input  cpu_we, cpu_a0, cpu_din, ovf_clr,
        output full, level, overflow, saa_cs_n, saa_a0, saa_wr_n, saa_din
    );
endinterface

// File: rtl/saa1099_wr_queue.sv
// Buffers CPU register writes and replays them to the SAA1099 as cs_n/wr_n strobes.
// Build macro SAA1099_WRQ_COALESCE_EN: merge a new address write into a queued address write.
//
// state  | meaning
// IDLE   | nothing in flight, pop as soon as the queue is non-empty
// SETUP  | cs_n low, wr_n high, a0/din presented
// STROBE | cs_n low, wr_n low for PULSE cycles
// HOLD   | cs_n low, wr_n high, data still held
// GAP    | cs_n high for GAP cycles before the next write
module saa1099_wr_queue #(
    parameter int DEPTH_LOG2 = 3,
    parameter int PULSE      = 2,
    parameter int GAP        = 2
) (
    input logic               clk_sys,
    input logic               rst_n,
    saa1099_wr_queue_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [7:0] PULSE_LD = 8'(PULSE - 1);
    localparam logic [7:0] GAP_LD   = 8'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_GAP
    } state_t;

    state_t                 state;
    logic [7:0]             cnt;
    logic [8:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2-1:0]  wr_idx;
    logic [DEPTH_LOG2:0]    level_q;
    logic                   overflow_q;
    logic                   cs_n_q;
    logic                   wr_n_q;
    logic                   a0_q;
    logic [7:0]             din_q;
    logic [8:0]             head;
    logic                   slot_free;
    logic                   pop;
    logic                   coalesce;
    logic                   accept;
    logic                   drop;

    assign head = mem[rd_ptr];

    // The last GAP cycle doubles as the idle slot so back-to-back writes need no extra cycle.
    assign slot_free = (state == S_IDLE)
                    || (state == S_GAP && cnt == '0)
                    || (state == S_HOLD && GAP == 0);
    assign pop = slot_free && (level_q != '0);

`ifdef SAA1099_WRQ_COALESCE_EN
    logic [8:0] tail;

    function automatic logic is_env(input logic [7:0] d);
        return d[4:1] == 4'b1100;
    endfunction

    assign tail = mem[wr_ptr - PTR_ONE];
    assign coalesce = bus.cpu_we && bus.cpu_a0 && (level_q != '0) && tail[8]
                   && !is_env(bus.cpu_din) && !is_env(tail[7:0])
                   && !(pop && level_q == LVL_ONE);
`else
    assign coalesce = 1'b0;
`endif

    assign accept = bus.cpu_we && !coalesce && (!level_q[DEPTH_LOG2] || pop);
    assign drop   = bus.cpu_we && !coalesce && !accept;
    assign wr_idx = coalesce ? wr_ptr - PTR_ONE : wr_ptr;

    always_ff @(posedge clk_sys) begin
        if (accept || coalesce)
            mem[wr_idx] <= {bus.cpu_a0, bus.cpu_din};
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({accept, pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
            if (drop)
                overflow_q <= 1'b1;
            else if (bus.ovf_clr)
                overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            cs_n_q <= 1'b1;
            wr_n_q <= 1'b1;
            a0_q   <= 1'b0;
            din_q  <= '0;
        end else if (pop) begin
            state  <= S_SETUP;
            a0_q   <= head[8];
            din_q  <= head[7:0];
            cs_n_q <= 1'b0;
            wr_n_q <= 1'b1;
        end else begin
            case (state)
                S_SETUP: begin
                    state  <= S_STROBE;
                    wr_n_q <= 1'b0;
                    cnt    <= PULSE_LD;
                end
                S_STROBE: begin
                    if (cnt == '0) begin
                        state  <= S_HOLD;
                        wr_n_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    cs_n_q <= 1'b1;
                    if (GAP == 0) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_GAP;
                        cnt   <= GAP_LD;
                    end
                end
                S_GAP: begin
                    if (cnt == '0)
                        state <= S_IDLE;
                    else
                        cnt <= cnt - 8'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.full     = level_q[DEPTH_LOG2];
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
    assign bus.saa_cs_n = cs_n_q;
    assign bus.saa_wr_n = wr_n_q;
    assign bus.saa_a0   = a0_q;
    assign bus.saa_din  = din_q;
endmodule

// File: tb/tb_saa1099_wr_queue.sv
// Directed bench for saa1099_wr_queue: replay order via scoreboard, strobe timing, full/overflow, reset abort.
// Honours SAA1099_WRQ_COALESCE_EN when the design is built with it.
module tb_saa1099_wr_queue;
    localparam int DL2 = 3;

    logic clk_sys = 1'b0;
    logic rst_n;

    always #5 clk_sys = ~clk_sys;

    saa1099_wr_queue_if #(.DEPTH_LOG2(DL2)) bus ();

    saa1099_wr_queue #(.DEPTH_LOG2(DL2), .PULSE(2), .GAP(2)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_strobe = 0;
    int last_fall = -1;
    bit chk_spacing = 1'b0;
    logic [8:0] sb [$];
    int sb_rd = 0;
    logic prev_wr_n = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Scoreboard consumer: every falling wr_n with cs_n low is one replayed write.
    always @(negedge clk_sys) begin
        if (!rst_n) begin
            sb_rd = sb.size();
            prev_wr_n = 1'b1;
        end else begin
            if (prev_wr_n === 1'b1 && bus.saa_wr_n === 1'b0) begin
                n_strobe++;
                chk("strobe_cs_low", 32'(bus.saa_cs_n), 32'd0);
                if (sb_rd < sb.size()) begin
                    chk("replay_order", 32'({bus.saa_a0, bus.saa_din}), 32'(sb[sb_rd]));
                    sb_rd++;
                end else begin
                    chk("strobe_without_entry", 32'(sb_rd), 32'(sb.size()));
                end
                if (chk_spacing && last_fall >= 0)
                    chk("strobe_spacing", 32'(cyc - last_fall), 32'd6);
                last_fall = chk_spacing ? cyc : -1;
            end
            prev_wr_n = bus.saa_wr_n;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive(input logic we, input logic a0, input logic [7:0] din,
                         input logic clr, input bit expect_push);
        bus.cpu_we  = we;
        bus.cpu_a0  = a0;
        bus.cpu_din = din;
        bus.ovf_clr = clr;
        if (we && expect_push)
            sb.push_back({a0, din});
        tick();
        bus.cpu_we  = 1'b0;
        bus.ovf_clr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 300; k++) begin
            if (bus.level == 0 && sb_rd == sb.size() && bus.saa_cs_n === 1'b1)
                break;
            tick();
        end
        chk(tag, 32'(k < 300), 32'd1);
        repeat (4) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        rst_n       = 1'b0;
        bus.cpu_we  = 1'b0;
        bus.cpu_a0  = 1'b0;
        bus.cpu_din = 8'h00;
        bus.ovf_clr = 1'b0;
        repeat (3) tick();
        chk("rst_cs_n", 32'(bus.saa_cs_n), 32'd1);
        chk("rst_wr_n", 32'(bus.saa_wr_n), 32'd1);
        chk("rst_a0", 32'(bus.saa_a0), 32'd0);
        chk("rst_din", 32'(bus.saa_din), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single write from idle: cycle-exact strobe shape
        drive(1'b1, 1'b1, 8'h1C, 1'b0, 1'b1);
        chk("single_level_c1", 32'(bus.level), 32'd1);
        tick();
        chk("single_cs_c2", 32'(bus.saa_cs_n), 32'd0);
        chk("single_wr_c2", 32'(bus.saa_wr_n), 32'd1);
        chk("single_a0_c2", 32'(bus.saa_a0), 32'd1);
        chk("single_din_c2", 32'(bus.saa_din), 32'h1C);
        chk("single_level_c2", 32'(bus.level), 32'd0);
        tick();
        chk("single_cs_c3", 32'(bus.saa_cs_n), 32'd0);
        chk("single_wr_c3", 32'(bus.saa_wr_n), 32'd0);
        tick();
        chk("single_wr_c4", 32'(bus.saa_wr_n), 32'd0);
        tick();
        chk("single_cs_c5", 32'(bus.saa_cs_n), 32'd0);
        chk("single_wr_c5", 32'(bus.saa_wr_n), 32'd1);
        chk("single_din_c5", 32'(bus.saa_din), 32'h1C);
        tick();
        chk("single_cs_c6", 32'(bus.saa_cs_n), 32'd1);
        wait_idle("single_drain");

        // Burst to full, overflow, clear, push+pop at full, set-wins-over-clear
        s0 = n_strobe;
        chk_spacing = 1'b1;
        for (int i = 0; i < 10; i++)
            drive(1'b1, i[0], 8'(i), 1'b0, 1'b1);
        drive(1'b1, 1'b0, 8'h0A, 1'b0, 1'b0);
        chk("burst_full", 32'(bus.full), 32'd1);
        chk("burst_level", 32'(bus.level), 32'd8);
        chk("burst_overflow_set", 32'(bus.overflow), 32'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("burst_overflow_clr", 32'(bus.overflow), 32'd0);
        chk("burst_level_hold", 32'(bus.level), 32'd8);
        tick();
        drive(1'b1, 1'b0, 8'h0B, 1'b0, 1'b1);
        chk("pushpop_level", 32'(bus.level), 32'd8);
        chk("pushpop_full", 32'(bus.full), 32'd1);
        chk("pushpop_overflow", 32'(bus.overflow), 32'd0);
        drive(1'b1, 1'b0, 8'h0C, 1'b1, 1'b0);
        chk("drop_vs_clr_overflow", 32'(bus.overflow), 32'd1);
        chk("drop_vs_clr_level", 32'(bus.level), 32'd8);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("second_clr", 32'(bus.overflow), 32'd0);
        wait_idle("burst_drain");
        chk_spacing = 1'b0;
        chk("burst_strobe_count", 32'(n_strobe - s0), 32'd11);

        // Reset during STROBE with 3 entries queued
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0, 1'b1);
        chk("rstmid_level", 32'(bus.level), 32'd3);
        chk("rstmid_in_strobe", 32'(bus.saa_wr_n), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_wr_n", 32'(bus.saa_wr_n), 32'd1);
        chk("rstmid_cs_n", 32'(bus.saa_cs_n), 32'd1);
        chk("rstmid_level0", 32'(bus.level), 32'd0);
        chk("rstmid_full", 32'(bus.full), 32'd0);
        chk("rstmid_din", 32'(bus.saa_din), 32'd0);
        s0 = n_strobe;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("rstmid_no_more_strobes", 32'(n_strobe), 32'(s0));
        chk("rstmid_level_after", 32'(bus.level), 32'd0);
        chk("rstmid_cs_after", 32'(bus.saa_cs_n), 32'd1);

        // Address write merging (or not) while the queue is busy
        s0 = n_strobe;
        drive(1'b1, 1'b0, 8'h55, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 8'h66, 1'b0, 1'b1);
`ifdef SAA1099_WRQ_COALESCE_EN
        drive(1'b1, 1'b1, 8'h08, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'h09, 1'b0, 1'b1);
        chk("coal_level_after_09", 32'(bus.level), 32'd2);
`else
        drive(1'b1, 1'b1, 8'h08, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 8'h09, 1'b0, 1'b1);
        chk("coal_level_after_09", 32'(bus.level), 32'd3);
`endif
        drive(1'b1, 1'b1, 8'h18, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 8'h18, 1'b0, 1'b1);
`ifdef SAA1099_WRQ_COALESCE_EN
        chk("coal_level_after_18", 32'(bus.level), 32'd4);
        chk("coal_no_overflow", 32'(bus.overflow), 32'd0);
        wait_idle("coal_drain");
        chk("coal_strobe_count", 32'(n_strobe - s0), 32'd5);
`else
        chk("coal_level_after_18", 32'(bus.level), 32'd5);
        chk("coal_no_overflow", 32'(bus.overflow), 32'd0);
        wait_idle("coal_drain");
        chk("coal_strobe_count", 32'(n_strobe - s0), 32'd6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/saa1099_wr_queue.md
# saa1099_wr_queue

Write-buffering bus front-end that sits directly upstream of the SAA1099 sound generator. It accepts single-cycle register writes from the CPU port decoder at full `clk_sys` rate and stores them in a small FIFO. It replays each write to the sound generator as a clean, well-separated chip-select/write-strobe sequence. The sound generator only registers a write on a high-to-low transition of `wr_n` while `cs_n` is low, so back-to-back CPU writes would otherwise be lost.

## Interface
Parameters:
- `DEPTH_LOG2`, 3: FIFO depth is 2^DEPTH_LOG2 entries (9 bits each: a0 + data).
- `PULSE`, 2: cycles `saa_wr_n` is held low per write (≥1).
- `GAP`, 2: idle cycles with `saa_cs_n`=1 between replayed writes (≥0).

Ports:
- `clk_sys`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cpu_we`  in  1  one-cycle write request.
- `cpu_a0`  in  1  0=data write, 1=address write.
- `cpu_din`  in  8  write data.
- `ovf_clr`  in  1  clears `overflow`.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- `level`  out  DEPTH_LOG2+1  current entry count.
- `overflow`  out  1  sticky: a write was dropped.
- `saa_cs_n`  out  1  to sound generator `cs_n`.
- `saa_a0`  out  1  to sound generator `a0`.
- `saa_wr_n`  out  1  to sound generator `wr_n`.
- `saa_din`  out  8  to sound generator `din`.

## Operation
- Reset values: `saa_cs_n`=1, `saa_wr_n`=1, `saa_a0`=0, `saa_din`=0, `full`=0, `level`=0, `overflow`=0. FIFO pointers are zeroed and the FSM is in IDLE.
- Push: `cpu_we`=1 is accepted if `level` < depth, or if a pop occurs in the same cycle. Otherwise the write is dropped and `overflow` is set.
- `ovf_clr` and a dropped write in the same cycle: `overflow` ends at 1 (set wins).
- FSM: IDLE → SETUP → STROBE → HOLD → GAP → IDLE. When GAP=0, HOLD goes directly to IDLE.
  - IDLE: if `level`≠0, pop the head entry, register its a0/din onto `saa_a0`/`saa_din`, and go to SETUP.
  - SETUP (1 cycle): `saa_cs_n`=0, `saa_wr_n`=1.
  - STROBE (PULSE cycles): `saa_cs_n`=0, `saa_wr_n`=0.
  - HOLD (1 cycle): `saa_cs_n`=0, `saa_wr_n`=1. `saa_a0`/`saa_din` remain stable from SETUP through HOLD.
  - GAP (GAP cycles): `saa_cs_n`=1, `saa_wr_n`=1.
- A pop decrements `level` in the cycle of the IDLE→SETUP transition.
- Simultaneous push and pop: `level` is unchanged.
- Write order is preserved exactly. Pointers wrap modulo depth.
- Mid-operation reset: asserting `rst_n` low immediately forces the outputs to their reset values. This aborts any strobe in progress and flushes all queued entries.

## Timing
- All outputs are registered; there is no combinational path from `cpu_*` to `saa_*`.
- Latency with the queue empty and the FSM idle:
  - Push in cycle 0 → `level`=1 in cycle 1.
  - SETUP outputs visible in cycle 2.
  - `saa_wr_n` falls in cycle 3.
- Throughput: one replayed write every 2+PULSE+GAP cycles (6 with defaults).
- `full` and `level` update in the cycle after the push/pop edge.

## Configuration
- `SAA1099_WRQ_COALESCE_EN` defined: an incoming address write replaces the tail entry in place instead of pushing a new entry. This happens only when all of the following hold:
  - `level`≥1;
  - the tail entry is also an address write;
  - neither the incoming nor the tail `din[4:0]` is 0x18 or 0x19 (those address writes clock the external envelopes and must all reach the chip).
  - A coalesced write never sets `overflow` and leaves `level` unchanged.
  - If the only entry is being popped in the same cycle, the write is pushed normally, not coalesced.
- Macro undefined: every accepted write occupies its own entry; there is no coalescing logic.

## Test plan
- Single write: push a0=1, din=0x1C with the queue idle → `saa_cs_n` low cycles 2–5, `saa_wr_n` low cycles 3–4, `saa_a0`=1, `saa_din`=0x1C stable cycles 2–5; `level` 1→0.
- Burst: 8 consecutive pushes (0x00..0x07, alternating a0) → replayed in order, one falling `saa_wr_n` edge every 6 cycles, `full`=1 after the 8th push. A 9th push while full with no pop → dropped, `overflow`=1. `ovf_clr` → 0.
- Push on the same cycle as a pop with `level`=8 → accepted, `level` stays 8, `overflow` stays 0.
- Assert `rst_n` low during STROBE with 3 entries queued → `saa_wr_n`=1 and `saa_cs_n`=1 immediately, `level`=0; no further strobes after release.
- With `SAA1099_WRQ_COALESCE_EN`: queue busy, push address 0x08 then address 0x09 → a single queued entry with 0x09. Push address 0x18 then address 0x18 → two entries, two strobes.
- Without `SAA1099_WRQ_COALESCE_EN`: the same address 0x08/0x09 sequence → two entries, two strobes.
